ddr_axi_test_master: RTL and testbench
======================================

Name: ddr_axi_test_master

Overview:
- AXI-side initiator that drives the DDR3_50H user port: writes a deterministic address-derived pattern to a DDR region in fixed-length bursts, reads it back, compares, and reports pass/fail.
- Sits in the axi_aclk domain, in front of the DDR controller. Serves as the bring-up traffic source and memory-test engine for the DDR test design.

Parameters:
CTRL_ADDR_WIDTH, 28, controller address width (row+column+bank)
MEM_DQ_WIDTH, 32, DDR DQ width; beat data = MEM_DQ_WIDTH*8 bits, lanes = 8
BURST_LEN, 16, beats per burst (1..16); axi_awlen/axi_arlen = BURST_LEN-1
START_ADDR, 0, first beat address (multiple of 8)
TEST_BEATS, 1024, total beats tested (multiple of BURST_LEN)
AXI_ID, 0, value driven on axi_awuser_id/axi_aruser_id

Ports:
axi_aclk  in  1  clock, controller user clock
axi_aresetn  in  1  asynchronous active-low reset
ddr_init_done  in  1  controller calibration complete
start  in  1  level; sampled in IDLE/DONE
axi_awaddr  out  CTRL_ADDR_WIDTH  write burst address
axi_awuser_ap  out  1  tied 0
axi_awuser_id  out  4  AXI_ID
axi_awlen  out  4  BURST_LEN-1
axi_awvalid  out  1  write address valid
axi_awready  in  1  write address accept
axi_wdata  out  MEM_DQ_WIDTH*8  write beat data
axi_wstrb  out  MEM_DQ_WIDTH  all ones
axi_wready  in  1  beat consumed this cycle (no wvalid; data must be present)
axi_wusero_last  in  1  controller last-beat flag
axi_araddr  out  CTRL_ADDR_WIDTH  read burst address
axi_aruser_ap  out  1  tied 0
axi_aruser_id  out  4  AXI_ID
axi_arlen  out  4  BURST_LEN-1
axi_arvalid  out  1  read address valid
axi_arready  in  1  read address accept
axi_rdata  in  MEM_DQ_WIDTH*8  read beat data
axi_rid  in  4  read id (ignored)
axi_rlast  in  1  last read beat
axi_rvalid  in  1  read beat valid (no rready; always accepted)
busy  out  1  test in progress
done  out  1  test complete, held until next start
pass  out  1  valid when done; 1 = err_cnt==0
err_cnt  out  16  mismatch count, saturating at 16'hFFFF
first_err_addr  out  CTRL_ADDR_WIDTH  beat address of first error

Behaviour:
- Reset (async assert, sync deassert inside): state IDLE. All outputs 0 except constant ties: awlen/arlen = BURST_LEN-1, wstrb all ones, ids = AXI_ID. Reset mid-transfer drops awvalid/arvalid immediately; no burst completion.
- Addressing: unit = one 32-bit word; each beat = 8 words, so beat address advances by 8 and burst address by 8*BURST_LEN. Addresses wrap modulo 2^CTRL_ADDR_WIDTH.
- Pattern: lane k (bits 32k+31:32k) of the beat at address A = 32-bit zero-extended A + k.
- States:
  - IDLE: on start=1, clear err_cnt/first_err_addr/done/pass, set busy -> WAIT_INIT.
  - DONE: same transition as IDLE on start=1.
  - WAIT_INIT: ddr_init_done=1 -> WR_ADDR.
  - WR_ADDR: awvalid=1, awaddr = current burst address, held stable until awready=1 (same-cycle accept allowed) -> WR_DATA, beat cnt=0.
  - WR_DATA: wdata = pattern(burst address + 8*cnt), combinational from cnt. Each cycle with wready=1, cnt+1. After beat BURST_LEN-1 accepted: more bursts remain -> WR_ADDR with next address; else -> RD_ADDR at START_ADDR.
  - RD_ADDR: arvalid/araddr handshake, same rules as WR_ADDR -> RD_DATA.
  - RD_DATA: every rvalid beat compared with pattern(burst address + 8*cnt). Any lane differing = one error for that beat. rlast with cnt != BURST_LEN-1, or cnt reaching BURST_LEN without rlast, = one additional error. Burst ends on rlast: more bursts remain -> RD_ADDR; else -> DONE.
  - DONE: busy=0, done=1, pass = (err_cnt==0).
- Error recording: first_err_addr latched on the first error only. err_cnt saturates.
- One outstanding burst at a time; no write/read overlap.
- start while busy is ignored. wusero_last is ignored by design.

Test Plan:
1. BURST_LEN=4, TEST_BEATS=8, START_ADDR=0x100, ideal responder -> AW 0x100/len3 then 0x120/len3; beat0 lane0=0x100, lane7=0x107; AR 0x100, 0x120; done=1, pass=1, err_cnt=0.
2. start=1 with ddr_init_done=0 for 50 cycles -> awvalid stays 0; first awvalid the cycle after ddr_init_done rises.
3. Responder flips bit0 of lane0 on read beat at 0x128 -> err_cnt=1, first_err_addr=0x128, pass=0.
4. awready delayed 10 cycles, wready asserted every other cycle -> awaddr stable while waiting; exactly 8 unique beats written in order; pass=1.
5. axi_aresetn pulsed low during WR_DATA beat 2 -> all outputs reset asynchronously; subsequent start gives full run with pass=1.
6. Responder asserts rlast on beat 2 of a 4-beat burst -> err_cnt increments by 1 for that burst; next AR issued; pass=0.

Source files
------------

// File: rtl/ddr_axi_test_master.sv
`default_nettype none
// =============================================================================
// Module : ddr_axi_test_master
// Brief  : writes an address-derived pattern over the DDR3 AXI user port, reads
//          it back, compares it and reports pass/fail with an error count.
// Rev    : 1.0
// =============================================================================
module ddr_axi_test_master #(
  parameter int          CTRL_ADDR_WIDTH = 28,
  parameter int          MEM_DQ_WIDTH    = 32,
  parameter int          BURST_LEN       = 16,
  parameter int unsigned START_ADDR      = 0,
  parameter int          TEST_BEATS      = 1024,
  parameter logic [3:0]  AXI_ID          = 4'd0
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic                         ddr_init_done,
  input  logic                         start,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                         axi_awuser_ap,
  output logic [3:0]                   axi_awuser_id,
  output logic [3:0]                   axi_awlen,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata,
  output logic [MEM_DQ_WIDTH-1:0]      axi_wstrb,
  input  logic                         axi_wready,
  input  logic                         axi_wusero_last,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic                         axi_aruser_ap,
  output logic [3:0]                   axi_aruser_id,
  output logic [3:0]                   axi_arlen,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic [3:0]                   axi_rid,
  input  logic                         axi_rlast,
  input  logic                         axi_rvalid,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [15:0]                  err_cnt,
  output logic [CTRL_ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int c_LANES  = 8;
  localparam int c_LANE_W = MEM_DQ_WIDTH;
  localparam int c_BEAT_W = MEM_DQ_WIDTH * 8;

  localparam logic [CTRL_ADDR_WIDTH-1:0] c_START      = CTRL_ADDR_WIDTH'(START_ADDR);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_BURST_STEP = CTRL_ADDR_WIDTH'(8 * BURST_LEN);
  localparam logic [4:0]                 c_LAST_BEAT  = 5'(BURST_LEN - 1);
  localparam logic [31:0]                c_LAST_BURST = 32'(TEST_BEATS / BURST_LEN - 1);

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_WAIT_INIT = 3'd1;
  localparam logic [2:0] c_ST_WR_ADDR   = 3'd2;
  localparam logic [2:0] c_ST_WR_DATA   = 3'd3;
  localparam logic [2:0] c_ST_RD_ADDR   = 3'd4;
  localparam logic [2:0] c_ST_RD_DATA   = 3'd5;
  localparam logic [2:0] c_ST_DONE      = 3'd6;

  logic [1:0]                 r_rst_sync;
  logic                       w_rst_n;
  logic [2:0]                 r_state;
  logic [CTRL_ADDR_WIDTH-1:0] r_addr;
  logic [4:0]                 r_cnt;
  logic [31:0]                r_burst;
  logic                       r_busy;
  logic                       r_done;
  logic [15:0]                r_err_cnt;
  logic [CTRL_ADDR_WIDTH-1:0] r_first_err_addr;

  logic [CTRL_ADDR_WIDTH-1:0] w_beat_addr;
  logic [c_BEAT_W-1:0]        w_pattern;
  logic                       w_data_err;
  logic                       w_len_err;
  logic [1:0]                 w_err_inc;
  logic [16:0]                w_err_sum;
  logic [15:0]                w_err_next;
  logic                       w_last_burst;
  logic                       w_unused;

  // Asynchronous assertion, release retimed onto axi_aclk
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_rst_sync <= 2'b00;
    else              r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_beat_addr = r_addr + CTRL_ADDR_WIDTH'({r_cnt, 3'b000});

  always_comb begin
    w_pattern = '0;
    for (int k = 0; k < c_LANES; k++) begin
      w_pattern[k*c_LANE_W +: c_LANE_W] = c_LANE_W'(w_beat_addr) + c_LANE_W'(k);
    end
  end

  // A short burst (rlast early) or an overrun (no rlast on the last beat) is one length error
  assign w_data_err   = (axi_rdata != w_pattern);
  assign w_len_err    = axi_rlast ? (r_cnt < c_LAST_BEAT) : (r_cnt == c_LAST_BEAT);
  assign w_err_inc    = {1'b0, w_data_err} + {1'b0, w_len_err};
  assign w_err_sum    = {1'b0, r_err_cnt} + 17'(w_err_inc);
  assign w_err_next   = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  assign w_last_burst = (r_burst == c_LAST_BURST);

  always_ff @(posedge axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state          <= c_ST_IDLE;
      r_addr           <= '0;
      r_cnt            <= '0;
      r_burst          <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (start) begin
            r_state          <= c_ST_WAIT_INIT;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_addr           <= c_START;
            r_cnt            <= '0;
            r_burst          <= '0;
          end
        end
        c_ST_WAIT_INIT: begin
          if (ddr_init_done) r_state <= c_ST_WR_ADDR;
        end
        c_ST_WR_ADDR: begin
          if (axi_awready) begin
            r_state <= c_ST_WR_DATA;
            r_cnt   <= '0;
          end
        end
        c_ST_WR_DATA: begin
          if (axi_wready) begin
            if (r_cnt == c_LAST_BEAT) begin
              r_cnt <= '0;
              if (w_last_burst) begin
                r_state <= c_ST_RD_ADDR;
                r_addr  <= c_START;
                r_burst <= '0;
              end else begin
                r_state <= c_ST_WR_ADDR;
                r_addr  <= r_addr + c_BURST_STEP;
                r_burst <= r_burst + 32'd1;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        c_ST_RD_ADDR: begin
          if (axi_arready) begin
            r_state <= c_ST_RD_DATA;
            r_cnt   <= '0;
          end
        end
        c_ST_RD_DATA: begin
          if (axi_rvalid) begin
            r_err_cnt <= w_err_next;
            if ((r_err_cnt == 16'd0) && (w_err_inc != 2'd0)) r_first_err_addr <= w_beat_addr;
            if (axi_rlast) begin
              r_cnt <= '0;
              if (w_last_burst) begin
                r_state <= c_ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= c_ST_RD_ADDR;
                r_addr  <= r_addr + c_BURST_STEP;
                r_burst <= r_burst + 32'd1;
              end
            end else if (r_cnt != 5'h1F) begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign axi_awvalid    = (r_state == c_ST_WR_ADDR);
  assign axi_awaddr     = axi_awvalid ? r_addr : '0;
  assign axi_awuser_ap  = 1'b0;
  assign axi_awuser_id  = AXI_ID;
  assign axi_awlen      = 4'(BURST_LEN - 1);
  assign axi_wdata      = (r_state == c_ST_WR_DATA) ? w_pattern : '0;
  assign axi_wstrb      = '1;
  assign axi_arvalid    = (r_state == c_ST_RD_ADDR);
  assign axi_araddr     = axi_arvalid ? r_addr : '0;
  assign axi_aruser_ap  = 1'b0;
  assign axi_aruser_id  = AXI_ID;
  assign axi_arlen      = 4'(BURST_LEN - 1);
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_done && (r_err_cnt == 16'd0);
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

  // The controller's own last-beat flag and the read id carry nothing this engine needs
  assign w_unused = ^{axi_rid, axi_wusero_last};

endmodule
`default_nettype wire

// File: tb/tb_ddr_axi_test_master.sv
`default_nettype none
// Bench for ddr_axi_test_master: memory-backed AXI responder with fault injection,
// a pattern/error reference model and a queue scoreboard drained by a monitor.
module tb_ddr_axi_test_master;

  localparam int          CAW   = 28;
  localparam int          DQ    = 32;
  localparam int          BW    = DQ * 8;
  localparam int          BL    = 4;
  localparam int          BEATS = 8;
  localparam int          NB    = BEATS / BL;
  localparam int unsigned START = 32'h100;
  localparam logic [3:0]  ID    = 4'h5;

  logic            clk;
  logic            axi_aresetn, ddr_init_done, start;
  logic [CAW-1:0]  axi_awaddr, axi_araddr, first_err_addr;
  logic            axi_awuser_ap, axi_aruser_ap, axi_awvalid, axi_arvalid;
  logic [3:0]      axi_awuser_id, axi_aruser_id, axi_awlen, axi_arlen, axi_rid;
  logic            axi_awready, axi_wready, axi_wusero_last, axi_arready, axi_rlast, axi_rvalid;
  logic [BW-1:0]   axi_wdata, axi_rdata;
  logic [DQ-1:0]   axi_wstrb;
  logic            busy, done, pass;
  logic [15:0]     err_cnt;

  ddr_axi_test_master #(
    .CTRL_ADDR_WIDTH(CAW), .MEM_DQ_WIDTH(DQ), .BURST_LEN(BL),
    .START_ADDR(START), .TEST_BEATS(BEATS), .AXI_ID(ID)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn), .ddr_init_done(ddr_init_done), .start(start),
    .axi_awaddr(axi_awaddr), .axi_awuser_ap(axi_awuser_ap), .axi_awuser_id(axi_awuser_id),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_aruser_ap(axi_aruser_ap), .axi_aruser_id(axi_aruser_id),
    .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]    err;
    logic [CAW-1:0] first;
    logic           pass;
  } res_t;

  logic [CAW-1:0] exp_aw_q[$];
  logic [CAW-1:0] exp_ar_q[$];
  logic [BW-1:0]  exp_w_q[$];
  res_t           exp_res_q[$];
  logic [BW-1:0]  mem [logic [CAW-1:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int w_beats_seen = 0;

  // responder knobs
  int             aw_delay, ar_delay, wready_mode, wready_pct, rvalid_pct;
  int             flip_en, flip_bit, early_en, early_beat;
  logic [CAW-1:0] flip_addr, early_addr;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [BW-1:0] pat(input logic [CAW-1:0] a);
    logic [BW-1:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'(a) + 32'(k);
    return p;
  endfunction

  function automatic logic [CAW-1:0] burst_addr(input int b);
    return CAW'(START + 32'(b * 8 * BL));
  endfunction

  // Reference model: expected traffic plus the error tally implied by the injected faults
  task automatic expect_run();
    int             err, n, e;
    logic [CAW-1:0] first, a, ba;
    err = 0; first = '0;
    for (int b = 0; b < NB; b++) begin
      a = burst_addr(b);
      exp_aw_q.push_back(a);
      exp_ar_q.push_back(a);
      for (int i = 0; i < BL; i++) exp_w_q.push_back(pat(a + CAW'(8 * i)));
    end
    for (int b = 0; b < NB; b++) begin
      a = burst_addr(b);
      n = (early_en != 0 && a == early_addr) ? early_beat + 1 : BL;
      for (int i = 0; i < n; i++) begin
        ba = a + CAW'(8 * i);
        e  = ((flip_en != 0 && ba == flip_addr) ? 1 : 0) + ((i == n - 1 && n != BL) ? 1 : 0);
        if (e != 0 && err == 0) first = ba;
        err += e;
      end
    end
    exp_res_q.push_back('{err: 16'(err), first: first, pass: (err == 0)});
  endtask

  task automatic flush();
    exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete(); exp_res_q.delete();
  endtask

  task automatic set_ideal();
    aw_delay = 0; ar_delay = 0; wready_mode = 0; wready_pct = 100; rvalid_pct = 100;
    flip_en = 0; flip_bit = 0; flip_addr = '0; early_en = 0; early_beat = 0; early_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, axi_awvalid, 0);
    check({tag, "_arvalid"}, axi_arvalid, 0);
    check({tag, "_awaddr"}, axi_awaddr, 0);
    check({tag, "_araddr"}, axi_araddr, 0);
    check({tag, "_wdata"}, axi_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_err"}, first_err_addr, 0);
    check({tag, "_awlen"}, axi_awlen, BL - 1);
    check({tag, "_arlen"}, axi_arlen, BL - 1);
    check({tag, "_wstrb"}, axi_wstrb, {DQ{1'b1}});
    check({tag, "_ids"}, {axi_awuser_id, axi_aruser_id}, {ID, ID});
    check({tag, "_ap"}, {axi_awuser_ap, axi_aruser_ap}, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("done_cleared_on_start", done, 0);
  endtask

  task automatic wait_done_and_drain(input string name);
    int base, cyc;
    base = done_seen - 1;
    cyc = 0;
    while (done_seen == base && cyc < 5000) begin @(posedge clk); cyc++; end
    if (done_seen == base) fail_now({name, "_timeout"});
    @(negedge clk);
    n_tests++;
    if (exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() + exp_res_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: aw=%0d w=%0d ar=%0d res=%0d left, required 0", name,
               exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size(), exp_res_q.size());
    end
  endtask

  task automatic run(input string name, input int init_wait);
    int base;
    base = done_seen;
    expect_run();
    if (init_wait > 0) ddr_init_done = 1'b0;
    pulse_start();
    if (init_wait > 0) begin
      repeat (init_wait) begin
        @(negedge clk);
        check("awvalid_before_init", axi_awvalid, 0);
      end
      @(posedge clk); #2 ddr_init_done = 1'b1;
      @(negedge clk); check("awvalid_init_edge", axi_awvalid, 0);
      @(negedge clk); check("awvalid_after_init", axi_awvalid, 1);
    end
    done_seen = done_seen;
    begin
      int cyc;
      cyc = 0;
      while (done_seen == base && cyc < 5000) begin @(posedge clk); cyc++; end
      if (done_seen == base) fail_now({name, "_timeout"});
    end
    @(negedge clk);
    n_tests++;
    if (exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() + exp_res_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: aw=%0d w=%0d ar=%0d res=%0d left, required 0", name,
               exp_aw_q.size(), exp_w_q.size(), exp_ar_q.size(), exp_res_q.size());
    end
  endtask

  // Slave side: samples handshakes at negedge, drives the next cycle's inputs after posedge
  initial begin : responder
    int             aw_wait, ar_wait, w_left, w_idx, rbeat;
    bit             wphase, last;
    logic [CAW-1:0] w_base, ba;
    logic [BW-1:0]  d;
    logic [CAW-1:0] rq[$];
    aw_wait = 0; ar_wait = 0; w_left = 0; w_idx = 0; rbeat = 0; wphase = 0; w_base = '0;
    forever begin
      @(negedge clk);
      if (!axi_aresetn) begin
        aw_wait = 0; ar_wait = 0; w_left = 0; w_idx = 0; rbeat = 0; wphase = 0; rq.delete();
      end else begin
        if (axi_awvalid && axi_awready) begin
          w_base = axi_awaddr; w_idx = 0; w_left = BL; aw_wait = 0;
        end else if (axi_awvalid) aw_wait++;
        if (axi_wready && w_left > 0) begin
          mem[w_base + CAW'(8 * w_idx)] = axi_wdata;
          w_idx++; w_left--;
        end
        if (axi_arvalid && axi_arready) begin
          rq.push_back(axi_araddr); ar_wait = 0; rbeat = 0;
        end else if (axi_arvalid) ar_wait++;
      end
      @(posedge clk); #2;
      axi_awready = axi_aresetn && axi_awvalid && (aw_wait >= aw_delay);
      axi_arready = axi_aresetn && axi_arvalid && (ar_wait >= ar_delay);
      if (axi_aresetn && w_left > 0) begin
        wphase = ~wphase;
        axi_wready = (wready_mode == 1) ? wphase : ($urandom_range(99) < 32'(wready_pct));
      end else axi_wready = 1'b0;
      axi_wusero_last = axi_wready && (w_left == 1);
      if (axi_aresetn && rq.size() > 0 && $urandom_range(99) < 32'(rvalid_pct)) begin
        ba = rq[0] + CAW'(8 * rbeat);
        d  = mem.exists(ba) ? mem[ba] : pat(ba);
        if (flip_en != 0 && ba == flip_addr) d[flip_bit] = ~d[flip_bit];
        last = (early_en != 0 && rq[0] == early_addr) ? (rbeat == early_beat) : (rbeat == BL - 1);
        axi_rvalid = 1'b1; axi_rdata = d; axi_rlast = last; axi_rid = ID;
        if (last) begin
          void'(rq.pop_front());
          rbeat = 0;
        end else rbeat++;
      end else begin
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        axi_rdata = {8{$urandom()}};
      end
    end
  end

  initial begin : monitor
    int             w_pend;
    bit             prev_done, prev_stall;
    logic [CAW-1:0] prev_awaddr;
    res_t           r;
    w_pend = 0; prev_done = 0; prev_stall = 0; prev_awaddr = '0;
    forever begin
      @(negedge clk);
      if (!axi_aresetn) begin
        w_pend = 0; prev_done = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("awvalid_held", axi_awvalid, 1);
          check("awaddr_stable", axi_awaddr, prev_awaddr);
        end
        prev_stall  = axi_awvalid && !axi_awready;
        prev_awaddr = axi_awaddr;
        if (axi_awvalid && axi_awready) begin
          if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
          else check("awaddr", axi_awaddr, exp_aw_q.pop_front());
          check("awlen", axi_awlen, BL - 1);
          w_pend = BL;
        end
        if (axi_wready && w_pend > 0) begin
          if (exp_w_q.size() == 0) fail_now("w_unexpected");
          else check("wdata", axi_wdata, exp_w_q.pop_front());
          w_pend--;
          w_beats_seen++;
        end
        if (axi_arvalid && axi_arready) begin
          if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
          else check("araddr", axi_araddr, exp_ar_q.pop_front());
          check("arlen", axi_arlen, BL - 1);
        end
        if (done && !prev_done) begin
          if (exp_res_q.size() == 0) fail_now("done_unexpected");
          else begin
            r = exp_res_q.pop_front();
            check("err_cnt", err_cnt, r.err);
            check("first_err_addr", first_err_addr, r.first);
            check("pass", pass, r.pass);
            check("busy_at_done", busy, 0);
          end
          done_seen++;
        end
        prev_done = done;
      end
    end
  end

  initial begin : main
    int base_w, cyc;
    axi_aresetn = 1'b1; ddr_init_done = 1'b1; start = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wusero_last = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0; axi_rid = '0;
    set_ideal();
    #3 axi_aresetn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 axi_aresetn = 1'b1;
    repeat (4) @(posedge clk);

    set_ideal();
    run("ideal", 0);

    set_ideal();
    run("init_wait", 50);

    set_ideal();
    flip_en = 1; flip_addr = CAW'(32'h128); flip_bit = 0;
    run("flip_0x128", 0);

    set_ideal();
    aw_delay = 10; wready_mode = 1;
    run("slow_aw_alt_w", 0);

    // abort in the middle of the first write burst, then a clean rerun
    set_ideal();
    expect_run();
    base_w = w_beats_seen;
    pulse_start();
    cyc = 0;
    while (w_beats_seen - base_w < 2 && cyc < 1000) begin @(posedge clk); cyc++; end
    if (w_beats_seen - base_w < 2) fail_now("mid_reset_wait_timeout");
    #3 axi_aresetn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    flush();
    repeat (2) @(posedge clk);
    #2 axi_aresetn = 1'b1;
    repeat (4) @(posedge clk);
    run("after_reset", 0);

    set_ideal();
    early_en = 1; early_addr = CAW'(START); early_beat = 2;
    run("early_rlast", 0);

    for (int t = 0; t < 8; t++) begin
      aw_delay    = int'($urandom_range(0, 4));
      ar_delay    = int'($urandom_range(0, 4));
      wready_mode = 0;
      wready_pct  = int'($urandom_range(30, 100));
      rvalid_pct  = int'($urandom_range(30, 100));
      flip_en     = int'($urandom_range(0, 1));
      flip_addr   = CAW'(START + 8 * $urandom_range(0, BEATS - 1));
      flip_bit    = int'($urandom_range(0, BW - 1));
      early_en    = int'($urandom_range(0, 1));
      early_addr  = burst_addr(int'($urandom_range(0, NB - 1)));
      early_beat  = int'($urandom_range(0, BL - 2));
      run("random", 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
